// File: rtl/pe_array_feeder_pkg.sv
// Package: pe_array_feeder_pkg
// Shared definitions for the PE array feeder: sequencer state encoding,
// precision codes and the default array geometry used to size the beats.
//   BITS_ACT  bits per activation lane
//   PE_ROW    rows in the PE array
//   N_BIAS    bias width
package pe_array_feeder_pkg;

    localparam int BITS_ACT = 32;
    localparam int PE_ROW   = 16;
    localparam int N_BIAS   = 32;

    // Per-operand precision codes; the 4-bit precision word is {act, wgt}.
    localparam logic [1:0] PREC_2B = 2'b00;
    localparam logic [1:0] PREC_4B = 2'b01;
    localparam logic [1:0] PREC_8B = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pe_array_feeder_feed_counter.sv
// Module: pe_array_feeder_feed_counter
// Up-counter with synchronous clear and enable that wraps to zero after
// reaching a programmable terminal value.
//   CLK     clock
//   RST     asynchronous active-high reset
//   i_Clr   synchronous clear (priority over enable)
//   i_En    advance the count
//   i_Last  terminal value; the count wraps to 0 after it
//   o_Tc    high while the count equals i_Last
module pe_array_feeder_feed_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_Clr,
    input  logic             i_En,
    input  logic [CNT_W-1:0] i_Last,
    output logic             o_Tc
);

    logic [CNT_W-1:0] cnt_q;

    assign o_Tc = (cnt_q == i_Last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (i_Clr) begin
            cnt_q <= '0;
        end else if (i_En) begin
            cnt_q <= o_Tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pe_array_feeder.sv
// Module: pe_array_feeder
// Transmit-side sequencer for the 16-row PE array. Pulls act/weight beats
// from the buffer read port (valid/ready), tags the first beat of every
// output with bias select, and closes each job with a drain beat so the
// array's done pulse fires for the last output.
// Optional feature macro: FEEDER_STALL_CNT_EN adds o_Stall_Cnt, a saturating
// count of FEED cycles with no upstream beat, cleared on each accepted start.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   i_Start                   job start pulse, honoured only in IDLE
//   i_Precision               {act[3:2], wgt[1:0]}, latched at start
//   i_Num_Chunks              beats per output (0 behaves as 1)
//   i_Num_Outs                outputs per job (0 = empty job)
//   s_Act/s_Weight/s_Bias     upstream beat and bias
//   s_Valid/s_Ready           upstream handshake; ready only in FEED
//   o_Act/o_Weight/o_Bias     registered beat and bias to the array
//   o_Precision               latched job precision
//   o_Sel_Bias/o_Flush        bias select / drain strobe
//   o_core_vld                accepted beat strobe
//   o_Busy, o_Job_Done        job in progress, job completion pulse
module pe_array_feeder
    import pe_array_feeder_pkg::*;
#(
    parameter int DATA_W = BITS_ACT * PE_ROW,
    parameter int BIAS_W = N_BIAS,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic [3:0]        i_Precision,
    input  logic [CNT_W-1:0]  i_Num_Chunks,
    input  logic [CNT_W-1:0]  i_Num_Outs,
    input  logic [DATA_W-1:0] s_Act,
    input  logic [DATA_W-1:0] s_Weight,
    input  logic [BIAS_W-1:0] s_Bias,
    input  logic              s_Valid,
    output logic              s_Ready,
    output logic [DATA_W-1:0] o_Act,
    output logic [DATA_W-1:0] o_Weight,
    output logic [3:0]        o_Precision,
    output logic [BIAS_W-1:0] o_Bias,
    output logic              o_Sel_Bias,
    output logic              o_Flush,
    output logic              o_core_vld,
    output logic              o_Busy,
    output logic              o_Job_Done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]       o_Stall_Cnt
`endif
);

    state_t state_q, state_d;
    logic   start_acc, beat_acc, last_beat;
    logic   chunk_tc, out_tc;
    logic   first_q;

    logic [CNT_W-1:0] chunk_last_q, out_last_q;
    logic [3:0]       prec_q;

    logic [DATA_W-1:0] act_p1, wgt_p1;
    logic [BIAS_W-1:0] bias_p1;
    logic              sel_p1, flush_p1, vld_p1, done_p1;

    assign s_Ready   = (state_q == ST_FEED);
    assign o_Busy    = (state_q != ST_IDLE);
    assign last_beat = chunk_tc & out_tc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        beat_acc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    start_acc = 1'b1;
                    state_d   = (i_Num_Outs == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                if (s_Valid) begin
                    beat_acc = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job configuration is stored as terminal values (count - 1) so the
    // counters compare directly; a zero chunk count collapses to one beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chunk_last_q <= '0;
            out_last_q   <= '0;
            prec_q       <= '0;
            first_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                chunk_last_q <= (i_Num_Chunks == '0) ? '0 : i_Num_Chunks - CNT_W'(1);
                out_last_q   <= i_Num_Outs - CNT_W'(1);
                prec_q       <= i_Precision;
                first_q      <= 1'b1;
            end else if (beat_acc) begin
                // The beat after a chunk wrap starts a new output.
                first_q <= chunk_tc;
            end
        end
    end

    pe_array_feeder_feed_counter #(.CNT_W(CNT_W)) u_chunk_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .i_Clr  (start_acc),
        .i_En   (beat_acc),
        .i_Last (chunk_last_q),
        .o_Tc   (chunk_tc)
    );

    pe_array_feeder_feed_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .i_Clr  (start_acc),
        .i_En   (beat_acc & chunk_tc),
        .i_Last (out_last_q),
        .o_Tc   (out_tc)
    );

    // ---- stage p1: registered array interface ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            act_p1   <= '0;
            wgt_p1   <= '0;
            bias_p1  <= '0;
            sel_p1   <= 1'b0;
            flush_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            sel_p1   <= 1'b0;
            flush_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            case (state_q)
                ST_FEED: begin
                    if (beat_acc) begin
                        act_p1 <= s_Act;
                        wgt_p1 <= s_Weight;
                        vld_p1 <= 1'b1;
                        if (first_q) begin
                            sel_p1  <= 1'b1;
                            bias_p1 <= s_Bias;
                        end
                    end
                end
                ST_DRAIN: begin
                    sel_p1   <= 1'b1;
                    flush_p1 <= 1'b1;
                    bias_p1  <= '0;
                end
                ST_DONE:  done_p1 <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign o_Act       = act_p1;
    assign o_Weight    = wgt_p1;
    assign o_Bias      = bias_p1;
    assign o_Sel_Bias  = sel_p1;
    assign o_Flush     = flush_p1;
    assign o_core_vld  = vld_p1;
    assign o_Job_Done  = done_p1;
    assign o_Precision = prec_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state_q == ST_FEED) && !s_Valid) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign o_Stall_Cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_array_feeder.sv
module tb_pe_array_feeder;

    localparam int DW = 512;
    localparam int BW = 32;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          i_Start;
    logic [3:0]    i_Precision;
    logic [CW-1:0] i_Num_Chunks, i_Num_Outs;
    logic [DW-1:0] s_Act, s_Weight;
    logic [BW-1:0] s_Bias;
    logic          s_Valid, s_Ready;
    logic [DW-1:0] o_Act, o_Weight;
    logic [3:0]    o_Precision;
    logic [BW-1:0] o_Bias;
    logic          o_Sel_Bias, o_Flush, o_core_vld, o_Busy, o_Job_Done;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]   o_Stall_Cnt;
`endif

    pe_array_feeder dut (
        .CLK          (CLK),
        .RST          (RST),
        .i_Start      (i_Start),
        .i_Precision  (i_Precision),
        .i_Num_Chunks (i_Num_Chunks),
        .i_Num_Outs   (i_Num_Outs),
        .s_Act        (s_Act),
        .s_Weight     (s_Weight),
        .s_Bias       (s_Bias),
        .s_Valid      (s_Valid),
        .s_Ready      (s_Ready),
        .o_Act        (o_Act),
        .o_Weight     (o_Weight),
        .o_Precision  (o_Precision),
        .o_Bias       (o_Bias),
        .o_Sel_Bias   (o_Sel_Bias),
        .o_Flush      (o_Flush),
        .o_core_vld   (o_core_vld),
        .o_Busy       (o_Busy),
        .o_Job_Done   (o_Job_Done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .o_Stall_Cnt  (o_Stall_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          vld, sel, flush, done, busy, ready;
        logic [3:0]    prec;
        logic [DW-1:0] act, wgt;
        logic [BW-1:0] bias;
        logic [31:0]   stall;
    } obs_t;

    obs_t          log_q[$];     // one entry per cycle, index k = after edge k
    int            vld_idx[$];   // log indices carrying a beat
    logic [DW-1:0] act_l[$], wgt_l[$];
    logic [BW-1:0] bias_l[$];
    int            n_eff, tot;
    int            total = 0;
    int            bad = 0;

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.vld = o_core_vld; o.sel = o_Sel_Bias; o.flush = o_Flush;
        o.done = o_Job_Done; o.busy = o_Busy; o.ready = s_Ready;
        o.prec = o_Precision; o.act = o_Act; o.wgt = o_Weight; o.bias = o_Bias;
`ifdef FEEDER_STALL_CNT_EN
        o.stall = o_Stall_Cnt;
`else
        o.stall = '0;
`endif
        return o;
    endfunction

    // Reference model: beat b belongs to output b/N; its first chunk selects bias.
    function automatic logic exp_sel(int b);
        return (b % n_eff) == 0;
    endfunction

    function automatic logic [BW-1:0] exp_bias(int b);
        return bias_l[b - (b % n_eff)];
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (log_q[k]) if (log_q[k].done) n++;
        return n;
    endfunction

    // mode 0: always valid, 1: alternate valid, 2: random valid.
    // poke >= 0 pulses i_Start with a different config at that cycle.
    task automatic run_job(input logic [CW-1:0] nch, input logic [CW-1:0] nout,
                           input logic [3:0] prec, input int mode, input int ncyc,
                           input int fixed_bias, input int poke);
        int  idx;
        logic v, alt;
        log_q.delete(); vld_idx.delete();
        act_l.delete(); wgt_l.delete(); bias_l.delete();
        n_eff = (nch == 0) ? 1 : int'(nch);
        tot   = n_eff * int'(nout);
        for (int b = 0; b < tot; b++) begin
            act_l.push_back(rand_beat());
            wgt_l.push_back(rand_beat());
            bias_l.push_back((fixed_bias != 0) ? BW'(fixed_bias + b) : BW'($urandom));
        end
        @(negedge CLK);
        i_Start = 1'b1; i_Num_Chunks = nch; i_Num_Outs = nout; i_Precision = prec;
        s_Valid = 1'b0;
        @(posedge CLK);
        idx = 0; alt = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            log_q.push_back(sample());
            if (log_q[c].vld) vld_idx.push_back(c);
            i_Start      = (c == poke);
            i_Precision  = (c == poke) ? 4'b0000 : 4'($urandom);
            i_Num_Chunks = CW'($urandom);
            i_Num_Outs   = (c == poke) ? '0 : CW'($urandom);
            case (mode)
                0:       v = 1'b1;
                1:       v = alt;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx < tot) alt = ~alt;
            if (idx < tot && v) begin
                s_Valid = 1'b1; s_Act = act_l[idx]; s_Weight = wgt_l[idx]; s_Bias = bias_l[idx];
                idx++;
            end else begin
                s_Valid = 1'b0; s_Act = rand_beat(); s_Weight = rand_beat(); s_Bias = BW'($urandom);
            end
        end
        s_Valid = 1'b0;
        i_Start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (o_core_vld !== 1'b0 || o_Sel_Bias !== 1'b0 || o_Flush !== 1'b0 || o_Job_Done !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: got vld=%b sel=%b flush=%b done=%b want 0", o_core_vld, o_Sel_Bias, o_Flush, o_Job_Done);
        end
        total++; if (o_Act !== '0 || o_Weight !== '0 || o_Bias !== '0 || o_Precision !== 4'b0) begin
            bad++; $display("FAIL reset_data: got bias=%h prec=%b want 0", o_Bias, o_Precision);
        end
        total++; if (s_Ready !== 1'b0 || o_Busy !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got ready=%b busy=%b want 0", s_Ready, o_Busy);
        end
    endtask

    task automatic test_full_rate();
        run_job(16'd4, 16'd2, 4'b1010, 0, 14, 0, -1);
        total++; if (vld_idx.size() != 8) begin
            bad++; $display("FAIL full_beat_count: got %0d want 8", vld_idx.size());
        end
        for (int b = 0; b < vld_idx.size() && b < 8; b++) begin
            total++; if (vld_idx[b] != b + 1 || log_q[vld_idx[b]].act !== act_l[b] || log_q[vld_idx[b]].wgt !== wgt_l[b]
                         || log_q[vld_idx[b]].sel !== exp_sel(b) || log_q[vld_idx[b]].bias !== exp_bias(b)) begin
                bad++; $display("FAIL full_beat%0d: got cycle=%0d sel=%b bias=%h want cycle=%0d sel=%b bias=%h",
                                b, vld_idx[b], log_q[vld_idx[b]].sel, log_q[vld_idx[b]].bias, b + 1, exp_sel(b), exp_bias(b));
            end
        end
        total++; if (log_q[9].sel !== 1'b1 || log_q[9].flush !== 1'b1 || log_q[9].vld !== 1'b0 || log_q[9].bias !== '0) begin
            bad++; $display("FAIL full_drain: got sel=%b flush=%b vld=%b bias=%h want 1 1 0 0",
                            log_q[9].sel, log_q[9].flush, log_q[9].vld, log_q[9].bias);
        end
        total++; if (log_q[10].done !== 1'b1 || count_done() != 1) begin
            bad++; $display("FAIL full_done: got done@10=%b pulses=%0d want 1 1", log_q[10].done, count_done());
        end
        total++; if (log_q[7].ready !== 1'b1 || log_q[8].ready !== 1'b0 || log_q[0].ready !== 1'b1) begin
            bad++; $display("FAIL full_ready: got r0=%b r7=%b r8=%b want 1 1 0", log_q[0].ready, log_q[7].ready, log_q[8].ready);
        end
        total++; if (log_q[9].busy !== 1'b1 || log_q[10].busy !== 1'b0 || log_q[1].prec !== 4'b1010) begin
            bad++; $display("FAIL full_busy_prec: got busy9=%b busy10=%b prec=%b want 1 0 1010",
                            log_q[9].busy, log_q[10].busy, log_q[1].prec);
        end
`ifdef FEEDER_STALL_CNT_EN
        total++; if (log_q[13].stall !== 32'd0) begin
            bad++; $display("FAIL full_stall: got %0d want 0", log_q[13].stall);
        end
`endif
    endtask

    task automatic test_stall_gaps();
        logic [DW-1:0] last_act;
        int gaps_bad;
        run_job(16'd4, 16'd2, 4'b1010, 1, 24, 0, -1);
        total++; if (vld_idx.size() != 8) begin
            bad++; $display("FAIL gap_beat_count: got %0d want 8", vld_idx.size());
        end
        for (int b = 0; b < vld_idx.size() && b < 8; b++) begin
            total++; if (log_q[vld_idx[b]].act !== act_l[b] || log_q[vld_idx[b]].wgt !== wgt_l[b]
                         || log_q[vld_idx[b]].sel !== exp_sel(b) || log_q[vld_idx[b]].bias !== exp_bias(b)) begin
                bad++; $display("FAIL gap_beat%0d: got sel=%b bias=%h want sel=%b bias=%h",
                                b, log_q[vld_idx[b]].sel, log_q[vld_idx[b]].bias, exp_sel(b), exp_bias(b));
            end
        end
        gaps_bad = 0;
        if (vld_idx.size() > 0) begin
            last_act = log_q[vld_idx[0]].act;
            for (int k = vld_idx[0]; k <= vld_idx[vld_idx.size()-1]; k++) begin
                if (log_q[k].vld) last_act = log_q[k].act;
                else if (log_q[k].act !== last_act || log_q[k].sel !== 1'b0) gaps_bad++;
            end
        end
        total++; if (gaps_bad != 0 || vld_idx.size() == 0) begin
            bad++; $display("FAIL gap_hold: got %0d gap cycles not holding, want 0", gaps_bad);
        end
        total++; if (count_done() != 1) begin
            bad++; $display("FAIL gap_done: got %0d pulses want 1", count_done());
        end
`ifdef FEEDER_STALL_CNT_EN
        total++; if (log_q[23].stall !== 32'd7) begin
            bad++; $display("FAIL gap_stall: got %0d want 7", log_q[23].stall);
        end
`endif
    endtask

    task automatic test_zero_chunks();
        run_job(16'd0, 16'd3, 4'b0101, 0, 8, 5, -1);
        total++; if (vld_idx.size() != 3) begin
            bad++; $display("FAIL zc_beat_count: got %0d want 3", vld_idx.size());
        end
        for (int b = 0; b < vld_idx.size() && b < 3; b++) begin
            total++; if (log_q[vld_idx[b]].sel !== 1'b1 || log_q[vld_idx[b]].bias !== BW'(5 + b)
                         || log_q[vld_idx[b]].act !== act_l[b]) begin
                bad++; $display("FAIL zc_beat%0d: got sel=%b bias=%0d want sel=1 bias=%0d",
                                b, log_q[vld_idx[b]].sel, log_q[vld_idx[b]].bias, 5 + b);
            end
        end
    endtask

    task automatic test_empty_job();
        int rdy = 0;
        run_job(16'd2, 16'd0, 4'b1001, 0, 6, 0, -1);
        foreach (log_q[k]) if (log_q[k].ready) rdy++;
        total++; if (vld_idx.size() != 0 || rdy != 0) begin
            bad++; $display("FAIL empty_traffic: got beats=%0d ready_cycles=%0d want 0 0", vld_idx.size(), rdy);
        end
        total++; if (log_q[1].done !== 1'b1 || count_done() != 1) begin
            bad++; $display("FAIL empty_done: got done@1=%b pulses=%0d want 1 1", log_q[1].done, count_done());
        end
        total++; if (log_q[0].busy !== 1'b1 || log_q[1].busy !== 1'b0) begin
            bad++; $display("FAIL empty_busy: got busy0=%b busy1=%b want 1 0", log_q[0].busy, log_q[1].busy);
        end
    endtask

    task automatic test_start_ignored();
        int prec_bad = 0;
        run_job(16'd4, 16'd2, 4'b1010, 0, 14, 0, 3);
        for (int k = 0; k < 12; k++) if (log_q[k].prec !== 4'b1010) prec_bad++;
        total++; if (prec_bad != 0) begin
            bad++; $display("FAIL busy_start_prec: got %0d cycles with prec!=1010, want 0", prec_bad);
        end
        total++; if (vld_idx.size() != 8 || count_done() != 1 || log_q[10].done !== 1'b1) begin
            bad++; $display("FAIL busy_start_job: got beats=%0d pulses=%0d want 8 1", vld_idx.size(), count_done());
        end
    endtask

    task automatic test_reset_mid_job();
        int dn = 0, vl = 0;
        @(negedge CLK);
        i_Start = 1'b1; i_Num_Chunks = 16'd4; i_Num_Outs = 16'd2; i_Precision = 4'b1010;
        @(negedge CLK);
        i_Start = 1'b0; s_Valid = 1'b1; s_Act = rand_beat(); s_Weight = rand_beat(); s_Bias = BW'($urandom);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        total++; if (o_core_vld !== 1'b0 || o_Sel_Bias !== 1'b0 || o_Act !== '0 || o_Bias !== '0 || o_Precision !== 4'b0) begin
            bad++; $display("FAIL midrst_outputs: got vld=%b sel=%b bias=%h prec=%b want 0", o_core_vld, o_Sel_Bias, o_Bias, o_Precision);
        end
        total++; if (s_Ready !== 1'b0 || o_Busy !== 1'b0) begin
            bad++; $display("FAIL midrst_state: got ready=%b busy=%b want 0 0", s_Ready, o_Busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (o_Job_Done) dn++;
            if (o_core_vld) vl++;
        end
        s_Valid = 1'b0;
        total++; if (dn != 0 || vl != 0) begin
            bad++; $display("FAIL midrst_quiet: got done=%0d beats=%0d want 0 0", dn, vl);
        end
        run_job(16'd3, 16'd2, 4'b0110, 0, 12, 0, -1);
        total++; if (vld_idx.size() != 6 || count_done() != 1 || log_q[1].act !== act_l[0] || log_q[1].sel !== 1'b1) begin
            bad++; $display("FAIL midrst_rerun: got beats=%0d pulses=%0d want 6 1", vld_idx.size(), count_done());
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 5; j++) begin
            logic [CW-1:0] nch, nout;
            int lastk, err;
            nch  = CW'($urandom_range(0, 5));
            nout = CW'($urandom_range(1, 4));
            run_job(nch, nout, 4'($urandom), 2, ((nch == 0) ? 1 : int'(nch)) * int'(nout) * 8 + 12, 0, -1);
            total++; if (vld_idx.size() != tot) begin
                bad++; $display("FAIL rnd%0d_count: got %0d want %0d", j, vld_idx.size(), tot);
            end
            err = 0;
            for (int b = 0; b < vld_idx.size() && b < tot; b++)
                if (log_q[vld_idx[b]].act !== act_l[b] || log_q[vld_idx[b]].wgt !== wgt_l[b]
                    || log_q[vld_idx[b]].sel !== exp_sel(b) || log_q[vld_idx[b]].bias !== exp_bias(b)) err++;
            total++; if (err != 0) begin
                bad++; $display("FAIL rnd%0d_beats: got %0d wrong beats want 0 (N=%0d outs=%0d)", j, err, n_eff, nout);
            end
            lastk = (vld_idx.size() > 0) ? vld_idx[vld_idx.size()-1] : 0;
            total++; if (lastk + 2 >= log_q.size() || log_q[lastk+1].flush !== 1'b1 || log_q[lastk+2].done !== 1'b1
                         || count_done() != 1) begin
                bad++; $display("FAIL rnd%0d_close: got drain/done missing after cycle %0d, pulses=%0d want 1", j, lastk, count_done());
            end
        end
    endtask

    initial begin
        RST = 1'b1; i_Start = 1'b0; i_Precision = '0; i_Num_Chunks = '0; i_Num_Outs = '0;
        s_Act = '0; s_Weight = '0; s_Bias = '0; s_Valid = 1'b0;
        test_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        test_full_rate();
        test_stall_gaps();
        test_zero_chunks();
        test_empty_job();
        test_start_ignored();
        test_reset_mid_job();
        test_random_jobs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
